// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU instructions until both
// operands are available (via issue bypass or broadcast wakeup), executes
// them, and presents a one-cycle result pulse on the per-slot result port.

package alu_rs_pkg;
  typedef struct packed {
    logic [3:0]  tag;
    logic        rdy;
    logic [31:0] data;
  } sal_t;
endpackage

module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int width    = 32,
  parameter int size     = 8,
  parameter int rob_size = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_alu_rs,
  input  logic [3:0]       issue_tag,
  input  logic [3:0]       issue_op,
  input  logic             src1_rdy,
  input  logic             src2_rdy,
  input  logic [3:0]       src1_tag,
  input  logic [3:0]       src2_tag,
  input  logic [width-1:0] src1_data,
  input  logic [width-1:0] src2_data,
  input  sal_t             rob_broadcast_bus [rob_size],
  output sal_t             alu_rs_o [size],
  output logic             stall_alu
);

  localparam int RW = $clog2(rob_size);

  typedef enum logic [1:0] {EMPTY, WAIT, READY, DONE} slot_state_t;

  logic [size-1:0] empty_vec;
  logic [size-1:0] alloc_sel;
  logic            do_alloc;

  // Operand values as seen at dispatch, after the broadcast bypass.
  logic             iss1_rdy, iss2_rdy;
  logic [width-1:0] iss1_val, iss2_val;

  function automatic logic [width-1:0] alu_calc(input logic [3:0] op,
                                                input logic [width-1:0] a,
                                                input logic [width-1:0] b);
    logic [width-1:0] r;
    r = '0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << b[4:0];
      4'd3: r = {{(width-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd4: r = {{(width-1){1'b0}}, (a < b)};
      4'd5: r = a ^ b;
      4'd6: r = a >> b[4:0];
      4'd7: r = $signed(a) >>> b[4:0];
      4'd8: r = a | b;
      4'd9: r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stall only when every slot is occupied; derived from registered state.
  assign stall_alu = ~|empty_vec;
  assign do_alloc  = load_alu_rs & ~stall_alu;

  // Pick the lowest-index empty slot for a new dispatch.
  always_comb begin
    alloc_sel = '0;
    for (int i = 0; i < size; i++) begin
      if (empty_vec[i] && (alloc_sel == '0)) alloc_sel[i] = 1'b1;
    end
  end

  // Issue bypass: a not-ready source whose producer broadcasts this cycle is captured directly.
  always_comb begin
    iss1_rdy = src1_rdy;
    iss1_val = src1_data;
    iss2_rdy = src2_rdy;
    iss2_val = src2_data;
    if (!src1_rdy && rob_broadcast_bus[src1_tag[RW-1:0]].rdy &&
        rob_broadcast_bus[src1_tag[RW-1:0]].tag == src1_tag) begin
      iss1_rdy = 1'b1;
      iss1_val = rob_broadcast_bus[src1_tag[RW-1:0]].data;
    end
    if (!src2_rdy && rob_broadcast_bus[src2_tag[RW-1:0]].rdy &&
        rob_broadcast_bus[src2_tag[RW-1:0]].tag == src2_tag) begin
      iss2_rdy = 1'b1;
      iss2_val = rob_broadcast_bus[src2_tag[RW-1:0]].data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < size; gi++) begin : g_slot
      slot_state_t      state_reg, state_next;
      logic [3:0]       op_reg, op_next;
      logic [3:0]       tag_reg, tag_next;
      logic             s1_rdy_reg, s1_rdy_next, s2_rdy_reg, s2_rdy_next;
      logic [3:0]       s1_tag_reg, s1_tag_next, s2_tag_reg, s2_tag_next;
      logic [width-1:0] s1_val_reg, s1_val_next, s2_val_reg, s2_val_next;
      sal_t             out_reg, out_next;
      sal_t             bc1, bc2;

      assign empty_vec[gi] = (state_reg == EMPTY);
      assign alu_rs_o[gi]  = out_reg;
      assign bc1 = rob_broadcast_bus[s1_tag_reg[RW-1:0]];
      assign bc2 = rob_broadcast_bus[s2_tag_reg[RW-1:0]];

      // Slot next-state: allocate, wake up operands, execute, release.
      always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        tag_next    = tag_reg;
        s1_rdy_next = s1_rdy_reg;
        s1_tag_next = s1_tag_reg;
        s1_val_next = s1_val_reg;
        s2_rdy_next = s2_rdy_reg;
        s2_tag_next = s2_tag_reg;
        s2_val_next = s2_val_reg;
        out_next    = out_reg;
        case (state_reg)
          EMPTY: begin
            if (do_alloc && alloc_sel[gi]) begin
              op_next     = issue_op;
              tag_next    = issue_tag;
              s1_rdy_next = iss1_rdy;
              s1_tag_next = src1_tag;
              s1_val_next = iss1_val;
              s2_rdy_next = iss2_rdy;
              s2_tag_next = src2_tag;
              s2_val_next = iss2_val;
              state_next  = (iss1_rdy && iss2_rdy) ? READY : WAIT;
            end
          end
          WAIT: begin
            if (!s1_rdy_reg && bc1.rdy && bc1.tag == s1_tag_reg) begin
              s1_rdy_next = 1'b1;
              s1_val_next = bc1.data;
            end
            if (!s2_rdy_reg && bc2.rdy && bc2.tag == s2_tag_reg) begin
              s2_rdy_next = 1'b1;
              s2_val_next = bc2.data;
            end
            if (s1_rdy_next && s2_rdy_next) state_next = READY;
          end
          READY: begin
            out_next.tag  = tag_reg;
            out_next.rdy  = 1'b1;
            out_next.data = alu_calc(op_reg, s1_val_reg, s2_val_reg);
            state_next    = DONE;
          end
          DONE: begin
            out_next   = '0;
            state_next = EMPTY;
          end
          default: begin
            out_next   = '0;
            state_next = EMPTY;
          end
        endcase
      end

      // Slot state registers; reset discards any in-flight instruction.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg  <= EMPTY;
          op_reg     <= '0;
          tag_reg    <= '0;
          s1_rdy_reg <= 1'b0;
          s1_tag_reg <= '0;
          s1_val_reg <= '0;
          s2_rdy_reg <= 1'b0;
          s2_tag_reg <= '0;
          s2_val_reg <= '0;
          out_reg    <= '0;
        end else begin
          state_reg  <= state_next;
          op_reg     <= op_next;
          tag_reg    <= tag_next;
          s1_rdy_reg <= s1_rdy_next;
          s1_tag_reg <= s1_tag_next;
          s1_val_reg <= s1_val_next;
          s2_rdy_reg <= s2_rdy_next;
          s2_tag_reg <= s2_tag_next;
          s2_val_reg <= s2_val_next;
          out_reg    <= out_next;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed testbench for alu_reservation_station.
module tb_alu_reservation_station;
  import alu_rs_pkg::*;

  logic        clk;
  logic        rst;
  logic        load_alu_rs;
  logic [3:0]  issue_tag, issue_op;
  logic        src1_rdy, src2_rdy;
  logic [3:0]  src1_tag, src2_tag;
  logic [31:0] src1_data, src2_data;
  sal_t        bus [8];
  sal_t        alu_rs_o [8];
  logic        stall_alu;

  int checks;
  int failures;

  alu_reservation_station #(.width(32), .size(8), .rob_size(8)) dut (
    .clk(clk),
    .rst(rst),
    .load_alu_rs(load_alu_rs),
    .issue_tag(issue_tag),
    .issue_op(issue_op),
    .src1_rdy(src1_rdy),
    .src2_rdy(src2_rdy),
    .src1_tag(src1_tag),
    .src2_tag(src2_tag),
    .src1_data(src1_data),
    .src2_data(src2_data),
    .rob_broadcast_bus(bus),
    .alu_rs_o(alu_rs_o),
    .stall_alu(stall_alu)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    load_alu_rs = 1'b0;
    issue_tag = '0; issue_op = '0;
    src1_rdy = 1'b0; src2_rdy = 1'b0;
    src1_tag = '0; src2_tag = '0;
    src1_data = '0; src2_data = '0;
  endtask

  task automatic clear_bus();
    for (int i = 0; i < 8; i++) bus[i] = '0;
  endtask

  task automatic drive_load(input logic [3:0] tag, input logic [3:0] op,
                            input logic r1, input logic [3:0] t1, input logic [31:0] d1,
                            input logic r2, input logic [3:0] t2, input logic [31:0] d2);
    load_alu_rs = 1'b1;
    issue_tag = tag; issue_op = op;
    src1_rdy = r1; src1_tag = t1; src1_data = d1;
    src2_rdy = r2; src2_tag = t2; src2_data = d2;
  endtask

  task automatic test_reset();
    #3;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (alu_rs_o[i] !== '0) begin
        failures++;
        $display("FAIL reset_out[%0d] got=%h exp=0", i, alu_rs_o[i]);
      end
    end
    checks++;
    if (stall_alu !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall got=%b exp=0", stall_alu);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_ready_dispatch();
    sal_t exp;
    exp = '{tag: 4'd3, rdy: 1'b1, data: 32'd12};
    @(negedge clk);
    drive_load(4'd3, 4'd0, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
    @(negedge clk);
    idle();
    checks++;
    if (alu_rs_o[0] !== '0) begin
      failures++;
      $display("FAIL ready_early got=%h exp=0", alu_rs_o[0]);
    end
    @(negedge clk);
    checks++;
    if (alu_rs_o[0] !== exp) begin
      failures++;
      $display("FAIL ready_result got=%h exp=%h", alu_rs_o[0], exp);
    end
    @(negedge clk);
    checks++;
    if (alu_rs_o[0] !== '0 || stall_alu !== 1'b0) begin
      failures++;
      $display("FAIL ready_release got=%h stall=%b exp=0 stall=0", alu_rs_o[0], stall_alu);
    end
    $display("test_ready_dispatch: add 5+7 tag 3 -> %h", exp);
  endtask

  task automatic test_wakeup();
    sal_t exp;
    exp = '{tag: 4'd2, rdy: 1'b1, data: 32'd7};
    @(negedge clk);
    drive_load(4'd2, 4'd1, 1'b1, 4'd0, 32'd10, 1'b0, 4'd5, 32'd0);
    @(negedge clk);
    idle();
    // A broadcast on index 5 carrying a different tag must not wake the slot.
    bus[5] = '{tag: 4'd13, rdy: 1'b1, data: 32'd99};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (alu_rs_o[0].rdy !== 1'b0) begin
        failures++;
        $display("FAIL wakeup_hold cyc=%0d got=%h exp=rdy0", c, alu_rs_o[0]);
      end
    end
    bus[5] = '{tag: 4'd5, rdy: 1'b1, data: 32'd3};
    @(negedge clk);
    clear_bus();
    checks++;
    if (alu_rs_o[0] !== '0) begin
      failures++;
      $display("FAIL wakeup_early got=%h exp=0", alu_rs_o[0]);
    end
    @(negedge clk);
    checks++;
    if (alu_rs_o[0] !== exp) begin
      failures++;
      $display("FAIL wakeup_result got=%h exp=%h", alu_rs_o[0], exp);
    end
    @(negedge clk);
    checks++;
    if (alu_rs_o[0] !== '0) begin
      failures++;
      $display("FAIL wakeup_release got=%h exp=0", alu_rs_o[0]);
    end
    $display("test_wakeup: sub 10-3 tag 2 -> %h", exp);
  endtask

  task automatic test_bypass();
    sal_t exp;
    exp = '{tag: 4'd4, rdy: 1'b1, data: 32'hFFFF_FFFF};
    @(negedge clk);
    drive_load(4'd4, 4'd7, 1'b0, 4'd1, 32'd0, 1'b1, 4'd0, 32'd4);
    bus[1] = '{tag: 4'd1, rdy: 1'b1, data: 32'hFFFF_FFFF};
    @(negedge clk);
    idle();
    clear_bus();
    @(negedge clk);
    checks++;
    if (alu_rs_o[0] !== exp) begin
      failures++;
      $display("FAIL bypass_result got=%h exp=%h", alu_rs_o[0], exp);
    end
    @(negedge clk);
    checks++;
    if (alu_rs_o[0] !== '0) begin
      failures++;
      $display("FAIL bypass_release got=%h exp=0", alu_rs_o[0]);
    end
    $display("test_bypass: sra 0xFFFFFFFF by 4 -> %h", exp);
  endtask

  task automatic test_fill();
    sal_t exp;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (stall_alu !== 1'b0) begin
        failures++;
        $display("FAIL fill_stall_early n=%0d got=%b exp=0", i, stall_alu);
      end
      drive_load(4'(i), 4'd0, 1'b1, 4'd0, 32'(i), 1'b0, 4'd7, 32'd0);
    end
    // Ninth load, fully ready, must be ignored while stalled.
    @(negedge clk);
    checks++;
    if (stall_alu !== 1'b1) begin
      failures++;
      $display("FAIL fill_stall got=%b exp=1", stall_alu);
    end
    drive_load(4'd15, 4'd0, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
    @(negedge clk);
    idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (alu_rs_o[i].rdy !== 1'b0) begin
          failures++;
          $display("FAIL fill_ignored slot=%0d got=%h exp=rdy0", i, alu_rs_o[i]);
        end
      end
    end
    bus[7] = '{tag: 4'd7, rdy: 1'b1, data: 32'd100};
    @(negedge clk);
    clear_bus();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      exp = '{tag: 4'(i), rdy: 1'b1, data: 32'(100 + i)};
      checks++;
      if (alu_rs_o[i] !== exp) begin
        failures++;
        $display("FAIL fill_pulse slot=%0d got=%h exp=%h", i, alu_rs_o[i], exp);
      end
    end
    checks++;
    if (stall_alu !== 1'b1) begin
      failures++;
      $display("FAIL fill_stall_done got=%b exp=1", stall_alu);
    end
    @(negedge clk);
    checks++;
    if (stall_alu !== 1'b0) begin
      failures++;
      $display("FAIL fill_stall_release got=%b exp=0", stall_alu);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (alu_rs_o[i] !== '0) begin
        failures++;
        $display("FAIL fill_release slot=%0d got=%h exp=0", i, alu_rs_o[i]);
      end
    end
    $display("test_fill: 8 slots filled, 9th ignored, 8 simultaneous pulses");
  endtask

  task automatic test_arith();
    logic [3:0]  ops [11];
    logic [31:0] as [11];
    logic [31:0] bs [11];
    logic [31:0] rs [11];
    sal_t exp;
    ops = '{4'd4, 4'd3, 4'd2, 4'd0, 4'd12, 4'd1, 4'd5, 4'd6, 4'd8, 4'd9, 4'd7};
    as  = '{32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd55, 32'd0, 32'hF0F0_F0F0,
            32'h8000_0000, 32'h0000_00F0, 32'h0000_0FF0, 32'h4000_0000};
    bs  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd33, 32'd1, 32'd66, 32'd1, 32'hFF00_FF00,
            32'd31, 32'h0000_000F, 32'h0000_00FF, 32'd2};
    rs  = '{32'd1, 32'd0, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h0FF0_0FF0,
            32'd1, 32'h0000_00FF, 32'h0000_00F0, 32'h1000_0000};
    for (int k = 0; k < 11; k++) begin
      exp = '{tag: 4'(k), rdy: 1'b1, data: rs[k]};
      @(negedge clk);
      drive_load(4'(k), ops[k], 1'b1, 4'd0, as[k], 1'b1, 4'd0, bs[k]);
      @(negedge clk);
      idle();
      @(negedge clk);
      checks++;
      if (alu_rs_o[0] !== exp) begin
        failures++;
        $display("FAIL arith op=%0d a=%h b=%h got=%h exp=%h", ops[k], as[k], bs[k], alu_rs_o[0], exp);
      end
      $display("test_arith: op=%0d a=%h b=%h exp=%h", ops[k], as[k], bs[k], rs[k]);
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    sal_t e1, e2, e3;
    e1 = '{tag: 4'd1, rdy: 1'b1, data: 32'd3};
    e2 = '{tag: 4'd2, rdy: 1'b1, data: 32'd7};
    e3 = '{tag: 4'd3, rdy: 1'b1, data: 32'd11};
    @(negedge clk);
    drive_load(4'd1, 4'd0, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2);
    @(negedge clk);
    drive_load(4'd2, 4'd0, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd4);
    @(negedge clk);
    // Slot 0 is DONE now, so this third load must land in slot 2.
    drive_load(4'd3, 4'd0, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd6);
    checks++;
    if (alu_rs_o[0] !== e1) begin
      failures++;
      $display("FAIL b2b_slot0 got=%h exp=%h", alu_rs_o[0], e1);
    end
    @(negedge clk);
    idle();
    checks++;
    if (alu_rs_o[1] !== e2 || alu_rs_o[0] !== '0) begin
      failures++;
      $display("FAIL b2b_slot1 got=%h/%h exp=%h/0", alu_rs_o[1], alu_rs_o[0], e2);
    end
    @(negedge clk);
    checks++;
    if (alu_rs_o[2] !== e3 || alu_rs_o[0] !== '0 || alu_rs_o[1] !== '0) begin
      failures++;
      $display("FAIL b2b_slot2 got=%h/%h/%h exp=0/0/%h", alu_rs_o[0], alu_rs_o[1], alu_rs_o[2], e3);
    end
    @(negedge clk);
    $display("test_back_to_back: three loads on consecutive edges -> slots 0,1,2");
  endtask

  task automatic test_reset_mid_op();
    sal_t exp;
    exp = '{tag: 4'd9, rdy: 1'b1, data: 32'd3};
    @(negedge clk);
    drive_load(4'd9, 4'd0, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2);
    @(negedge clk);
    idle();
    @(negedge clk);
    checks++;
    if (alu_rs_o[0] !== exp) begin
      failures++;
      $display("FAIL rstmid_pre got=%h exp=%h", alu_rs_o[0], exp);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (alu_rs_o[0] !== '0 || stall_alu !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async got=%h stall=%b exp=0 stall=0", alu_rs_o[0], stall_alu);
    end
    @(negedge clk);
    rst = 1'b0;
    // Reset while a slot is READY: its result must never appear.
    drive_load(4'd10, 4'd0, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 32'd4);
    @(negedge clk);
    idle();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (alu_rs_o[i].rdy !== 1'b0) begin
          failures++;
          $display("FAIL rstmid_pulse cyc=%0d slot=%0d got=%h exp=rdy0", c, i, alu_rs_o[i]);
        end
      end
    end
    $display("test_reset_mid_op: results discarded");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    idle();
    clear_bus();
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_bypass();
    test_fill();
    test_arith();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
